// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle sequencer that breaks 5-bit logical shifts
// into repeated passes through the ALU's 3-bit-shamt shifter. It stalls
// the EX stage while busy and returns the composed result on rsp_data.
module alu_shift_seq #(
   parameter int STEP_MAX = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_dir,
   input  logic [31:0] req_val,
   input  logic [4:0]  req_shamt,
   output logic        busy,
   output logic        alu_req,
   output logic        alu_dir,
   output logic [31:0] alu_val,
   output logic [2:0]  alu_shamt,
   input  logic [31:0] alu_rslt,
   output logic        rsp_valid,
   output logic [31:0] rsp_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [4:0] STEP_REM = 5'(STEP_MAX);
   localparam logic [2:0] STEP_AMT = 3'(STEP_MAX);

   state_t      state;
   state_t      next_state;
   logic [31:0] acc;
   logic [4:0]  rem;
   logic        dir;
   logic [31:0] rsp_reg;
   logic [2:0]  step;

   // Each pass shifts by the remaining amount, capped at what one ALU pass can do.
   // Because step never exceeds rem, the remaining count cannot underflow.
   assign step = (rem > STEP_REM) ? STEP_AMT : rem[2:0];

   // State register; reset abandons any in-flight shift without responding.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection: a zero-amount shift skips the ALU entirely.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               next_state = (req_shamt == 5'd0) ? DONE : ISSUE;
            end
         end
         ISSUE: next_state = WAIT;
         WAIT:  next_state = (rem == 5'd0) ? DONE : ISSUE;
         DONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: latch the request, count down the remaining shift, capture each
   // ALU result, and freeze the final value into the response register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= 32'd0;
         rem     <= 5'd0;
         dir     <= 1'b0;
         rsp_reg <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  acc <= req_val;
                  dir <= req_dir;
                  rem <= req_shamt;
                  if (req_shamt == 5'd0) begin
                     rsp_reg <= req_val;
                  end
               end
            end
            ISSUE: begin
               rem <= rem - {2'b00, step};
            end
            WAIT: begin
               acc <= alu_rslt;
               if (rem == 5'd0) begin
                  rsp_reg <= alu_rslt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decoded from the state; ALU operands idle at acc/dir/0 to avoid X.
   always_comb begin
      req_ready = (state == IDLE);
      busy      = (state != IDLE);
      alu_req   = (state == ISSUE);
      alu_dir   = dir;
      alu_val   = acc;
      alu_shamt = (state == ISSUE) ? step : 3'd0;
      rsp_valid = (state == DONE);
      rsp_data  = rsp_reg;
   end

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed and randomized checks of the shift sequencer,
// with a registered ALU shifter model beside each instance (STEP_MAX=7 and 1).
module tb_alu_shift_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_dir = 1'b0;
   logic [31:0] req_val = 32'd0;
   logic [4:0]  req_shamt = 5'd0;
   logic        use1 = 1'b0;

   logic        req_valid7, req_ready7, busy7, alu_req7, alu_dir7, rsp_valid7;
   logic [31:0] alu_val7, rsp_data7;
   logic [2:0]  alu_shamt7;
   logic [31:0] alu_rslt7 = 32'd0;

   logic        req_valid1, req_ready1, busy1, alu_req1, alu_dir1, rsp_valid1;
   logic [31:0] alu_val1, rsp_data1;
   logic [2:0]  alu_shamt1;
   logic [31:0] alu_rslt1 = 32'd0;

   logic        m_req_ready, m_rsp_valid;
   logic [31:0] m_rsp_data;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int max_passes [5] = '{7, 7, 7, 7, 3};

   logic        pend = 1'b0;
   logic [38:0] snap = '0;

   assign req_valid7  = req_valid & ~use1;
   assign req_valid1  = req_valid & use1;
   assign m_req_ready = use1 ? req_ready1 : req_ready7;
   assign m_rsp_valid = use1 ? rsp_valid1 : rsp_valid7;
   assign m_rsp_data  = use1 ? rsp_data1  : rsp_data7;

   alu_shift_seq #(.STEP_MAX(7)) dut7 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid7), .req_ready(req_ready7),
      .req_dir(req_dir), .req_val(req_val), .req_shamt(req_shamt),
      .busy(busy7),
      .alu_req(alu_req7), .alu_dir(alu_dir7), .alu_val(alu_val7),
      .alu_shamt(alu_shamt7), .alu_rslt(alu_rslt7),
      .rsp_valid(rsp_valid7), .rsp_data(rsp_data7)
   );

   alu_shift_seq #(.STEP_MAX(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_dir(req_dir), .req_val(req_val), .req_shamt(req_shamt),
      .busy(busy1),
      .alu_req(alu_req1), .alu_dir(alu_dir1), .alu_val(alu_val1),
      .alu_shamt(alu_shamt1), .alu_rslt(alu_rslt1),
      .rsp_valid(rsp_valid1), .rsp_data(rsp_data1)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // ALU shifter models with one cycle of registered latency.
   always @(posedge clk) begin
      if (alu_req7) alu_rslt7 <= alu_dir7 ? (alu_val7 >> alu_shamt7) : (alu_val7 << alu_shamt7);
      if (alu_req1) alu_rslt1 <= alu_dir1 ? (alu_val1 >> alu_shamt1) : (alu_val1 << alu_shamt1);
   end

   // Requester discipline: a pending request must hold all fields until accepted.
   always @(posedge clk) begin
      if (pend) begin
         total++;
         assert ({req_valid, req_dir, req_val, req_shamt} === snap) else begin
            bad++;
            $error("[TB] FAIL req_stable observed=%h expected=%h",
                   {req_valid, req_dir, req_val, req_shamt}, snap);
         end
      end
      pend <= req_valid && (m_req_ready !== 1'b1);
      snap <= {req_valid, req_dir, req_val, req_shamt};
   end

   // Advance one cycle; inputs are driven and outputs sampled 1 unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request and return in the cycle after it is accepted (T+1).
   task automatic applyStimulus(input logic dir, input logic [31:0] val, input logic [4:0] sh);
      int budget;
      req_valid = 1'b1;
      req_dir   = dir;
      req_val   = val;
      req_shamt = sh;
      budget    = 0;
      while (m_req_ready !== 1'b1 && budget < 100) begin
         step();
         budget++;
      end
      if (budget >= 100) checkOutput("accept_timeout", 32'd0, 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      logic        r_dir;
      logic [31:0] r_val, r_exp;
      logic [4:0]  r_sh;
      int          lat, n_pass, stepsz, exp_lat;

      // Reset and idle
      rst = 1'b1;
      step();
      step();
      checkOutput("rst_ready", req_ready7, 32'd1);
      checkOutput("rst_busy", busy7, 32'd0);
      checkOutput("rst_rsp_valid", rsp_valid7, 32'd0);
      checkOutput("rst_rsp_data", rsp_data7, 32'd0);
      checkOutput("rst_alu_req", alu_req7, 32'd0);
      rst = 1'b0;
      step();

      // Small shift: SLL 1 by 5
      applyStimulus(1'b0, 32'h0000_0001, 5'd5);
      checkOutput("small_alu_req", alu_req7, 32'd1);
      checkOutput("small_shamt", alu_shamt7, 32'd5);
      checkOutput("small_alu_val", alu_val7, 32'h0000_0001);
      checkOutput("small_busy", busy7, 32'd1);
      step();
      checkOutput("small_wait_req", alu_req7, 32'd0);
      step();
      checkOutput("small_rsp_valid", rsp_valid7, 32'd1);
      checkOutput("small_rsp_data", rsp_data7, 32'h0000_0020);
      step();
      checkOutput("small_rsp_pulse", rsp_valid7, 32'd0);
      checkOutput("small_rsp_hold", rsp_data7, 32'h0000_0020);
      checkOutput("small_idle_busy", busy7, 32'd0);

      // Max shift SRL 0x80000000 by 31 with a second request held while busy
      applyStimulus(1'b1, 32'h8000_0000, 5'd31);
      for (int k = 0; k < 5; k++) begin
         checkOutput("max_alu_req", alu_req7, 32'd1);
         checkOutput("max_shamt", alu_shamt7, 32'(max_passes[k]));
         checkOutput("max_alu_dir", alu_dir7, 32'd1);
         checkOutput("max_busy", busy7, 32'd1);
         if (k == 0) begin
            req_valid = 1'b1;
            req_dir   = 1'b0;
            req_val   = 32'h0000_0003;
            req_shamt = 5'd8;
         end
         step();
         checkOutput("max_wait_req", alu_req7, 32'd0);
         checkOutput("max_not_ready", req_ready7, 32'd0);
         checkOutput("max_wait_busy", busy7, 32'd1);
         step();
      end
      checkOutput("max_rsp_valid", rsp_valid7, 32'd1);
      checkOutput("max_rsp_data", rsp_data7, 32'h0000_0001);
      checkOutput("max_done_busy", busy7, 32'd1);
      checkOutput("max_done_ready", req_ready7, 32'd0);
      step();
      checkOutput("b2b_ready", req_ready7, 32'd1);
      checkOutput("b2b_idle_rsp", rsp_valid7, 32'd0);
      step();
      req_valid = 1'b0;
      checkOutput("b2b_pass0_req", alu_req7, 32'd1);
      checkOutput("b2b_pass0", alu_shamt7, 32'd7);
      step();
      step();
      checkOutput("b2b_pass1_req", alu_req7, 32'd1);
      checkOutput("b2b_pass1", alu_shamt7, 32'd1);
      step();
      step();
      checkOutput("b2b_rsp_valid", rsp_valid7, 32'd1);
      checkOutput("b2b_rsp_data", rsp_data7, 32'h0000_0300);
      step();

      // Zero shift bypasses the ALU
      applyStimulus(1'b0, 32'hDEAD_BEEF, 5'd0);
      checkOutput("zero_alu_req", alu_req7, 32'd0);
      checkOutput("zero_rsp_valid", rsp_valid7, 32'd1);
      checkOutput("zero_rsp_data", rsp_data7, 32'hDEAD_BEEF);
      checkOutput("zero_busy", busy7, 32'd1);
      step();
      checkOutput("zero_idle_busy", busy7, 32'd0);
      checkOutput("zero_rsp_pulse", rsp_valid7, 32'd0);

      // Reset during the first WAIT of a long shift
      applyStimulus(1'b1, 32'h8000_0000, 5'd31);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("mid_rst_ready", req_ready7, 32'd1);
      checkOutput("mid_rst_busy", busy7, 32'd0);
      checkOutput("mid_rst_rsp_valid", rsp_valid7, 32'd0);
      checkOutput("mid_rst_rsp_data", rsp_data7, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         checkOutput("mid_rst_quiet_req", alu_req7, 32'd0);
         checkOutput("mid_rst_quiet_rsp", rsp_valid7, 32'd0);
      end
      applyStimulus(1'b1, 32'h0000_00F0, 5'd4);
      checkOutput("fresh_shamt", alu_shamt7, 32'd4);
      step();
      step();
      checkOutput("fresh_rsp_valid", rsp_valid7, 32'd1);
      checkOutput("fresh_rsp_data", rsp_data7, 32'h0000_000F);
      step();

      // Random requests against a direct shift model, both step sizes
      for (int pass = 0; pass < 2; pass++) begin
         use1   = (pass == 1);
         stepsz = use1 ? 1 : 7;
         step();
         for (int i = 0; i < (use1 ? 400 : 1000); i++) begin
            r_dir  = 1'($urandom_range(0, 1));
            r_val  = $urandom;
            r_sh   = 5'($urandom_range(0, 31));
            r_exp  = r_dir ? (r_val >> r_sh) : (r_val << r_sh);
            n_pass = (int'(r_sh) + stepsz - 1) / stepsz;
            exp_lat = 2 * n_pass + 1;
            applyStimulus(r_dir, r_val, r_sh);
            lat = 1;
            while (m_rsp_valid !== 1'b1 && lat < 80) begin
               step();
               lat++;
            end
            checkOutput(use1 ? "rand1_latency" : "rand7_latency", 32'(lat), 32'(exp_lat));
            checkOutput(use1 ? "rand1_data" : "rand7_data", m_rsp_data, r_exp);
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
